// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared ALU/MDU encodings and MDU FSM state type
package mdu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] div,
    output logic [31:0] rem_nxt,
    output logic [31:0] quo_nxt
);
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // Shifted partial remainder can exceed 32 bits when the divisor is large.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, div};
    assign fits    = (shifted >= {1'b0, div});

    assign rem_nxt = fits ? diff[31:0] : shifted[31:0];
    assign quo_nxt = {quo[30:0], fits};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential RV32M multiply/divide unit
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    mdu_state_e  state_q, state_d;
    mdu_op_e     op_q, op_d;
    logic [32:0] a_q, a_d;
    logic [32:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        div_signed, a_neg, b_neg, a_sext, b_sext;
    logic [31:0] mag_a, mag_b;
    logic [31:0] step_rem, step_quo;
    logic [63:0] prod;

    mdu_div_step u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .div     (b_q[31:0]),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    // One signed 33x33 product serves all four variants via the extension bit.
    assign prod = $signed({{31{a_q[32]}}, a_q}) * $signed({{31{b_q[32]}}, b_q});

    assign accept     = i_valid && ready_q && !i_flush;
    assign div_signed = !i_op[0];
    assign a_neg      = div_signed && i_a[31];
    assign b_neg      = div_signed && i_b[31];
    assign mag_a      = a_neg ? (32'd0 - i_a) : i_a;
    assign mag_b      = b_neg ? (32'd0 - i_b) : i_b;
    assign a_sext     = (i_op != OP_MULHU) && i_a[31];
    assign b_sext     = ((i_op == OP_MUL) || (i_op == OP_MULH)) && i_b[31];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d = mdu_op_e'(i_op);
                    if (!i_op[2]) begin
                        a_d     = {a_sext, i_a};
                        b_d     = {b_sext, i_b};
                        state_d = ST_MUL;
                    end else if (i_b == 32'd0) begin
                        result_d = i_op[1] ? i_a : 32'hFFFF_FFFF;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (div_signed && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF) begin
                        result_d = i_op[1] ? 32'd0 : 32'h8000_0000;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        rem_d   = 32'd0;
                        quo_d   = mag_a;
                        b_d     = {1'b0, mag_b};
                        cnt_d   = 5'd31;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                result_d = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == 5'd0) state_d = ST_FIX;
                else               cnt_d   = cnt_q - 5'd1;
            end
            ST_FIX: begin
                if (op_q[1]) result_d = rneg_q ? (32'd0 - rem_q) : rem_q;
                else         result_d = qneg_q ? (32'd0 - quo_q) : quo_q;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d  = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed vector bench for mdu_seq
module tb_mdu_seq;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        i_flush = 1'b0;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    mdu_seq #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_done   (o_done),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Call at a negedge; request is accepted at the following posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_a     = 32'hDEAD_BEEF;
        i_b     = 32'h1234_5678;
    endtask

    // Latency k means o_done seen in the k-th cycle after the accept edge; 0 = timeout.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                lat = k;
                res = o_result;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic [31:0] prev;
        int          done_seen;

        vecs[0]  = '{3'b000, 32'd3,          32'd5,          2,  32'd15};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2,  32'h0000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2,  32'hFFFF_FFFE};
        vecs[4]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  2,  32'h4000_0000};
        vecs[5]  = '{3'b000, 32'hFFFF_FFFF,  32'd2,          2,  32'hFFFF_FFFE};
        vecs[6]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFD};
        vecs[7]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b101, 32'd123,        32'd0,          1,  32'hFFFF_FFFF};
        vecs[9]  = '{3'b111, 32'd123,        32'd0,          1,  32'd123};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  1,  32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  1,  32'd0};
        vecs[12] = '{3'b101, 32'd100,        32'd7,          34, 32'd14};
        vecs[13] = '{3'b111, 32'd100,        32'd7,          34, 32'd2};
        vecs[14] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  34, 32'hFFFF_FFFD};
        vecs[15] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          34, 32'hFFFF_FFFF};

        repeat (2) @(negedge i_clk);
        check("reset o_done", {31'd0, o_done}, 32'd0);
        check("reset o_result", o_result, 32'd0);
        check("reset o_ready", {31'd0, o_ready}, 32'd1);
        check("reset o_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, res);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d result", i), res, vecs[i].res);
        end

        // Flush at cycle +10 of a divide.
        @(negedge i_clk);
        prev = o_result;
        issue(3'b100, 32'd1000, 32'd3);
        repeat (9) @(negedge i_clk);
        check("flush busy before", {31'd0, o_busy}, 32'd1);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush o_ready", {31'd0, o_ready}, 32'd1);
        check("flush o_busy", {31'd0, o_busy}, 32'd0);
        check("flush o_result held", o_result, prev);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_done) done_seen++;
        end
        check("flush no o_done", 32'(done_seen), 32'd0);

        // Back-to-back: MUL accepted in the DONE cycle of DIVU.
        @(negedge i_clk);
        issue(3'b101, 32'd100, 32'd7);
        wait_done(lat, res);
        check("b2b divu latency", 32'(lat), 32'd34);
        check("b2b divu result", res, 32'd14);
        check("b2b ready in done", {31'd0, o_ready}, 32'd1);
        issue(3'b000, 32'd3, 32'd5);
        @(negedge i_clk);
        check("b2b no bubble busy", {31'd0, o_busy}, 32'd1);
        check("b2b no bubble done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        check("b2b mul done", {31'd0, o_done}, 32'd1);
        check("b2b mul result", o_result, 32'd15);

        // Asynchronous reset at cycle +20 of a divide.
        @(negedge i_clk);
        issue(3'b100, 32'd5000, 32'd7);
        repeat (20) @(negedge i_clk);
        check("rst busy before", {31'd0, o_busy}, 32'd1);
        check("rst ready before", {31'd0, o_ready}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("rst async o_result", o_result, 32'd0);
        check("rst async o_done", {31'd0, o_done}, 32'd0);
        check("rst async o_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_done) done_seen++;
        end
        check("rst no o_done", 32'(done_seen), 32'd0);
        issue(3'b011, 32'h8000_0000, 32'd4);
        wait_done(lat, res);
        check("post-rst mulhu latency", 32'(lat), 32'd2);
        check("post-rst mulhu result", res, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 The block SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port i_rst, input, 1: asynchronous active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1: request present.
REQ-005 The block SHALL have port o_ready, output, 1: request can be accepted this cycle.
REQ-006 The block SHALL have port i_op, input, 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have ports i_a and i_b, input, XLEN each: rs1 and rs2 operands.
REQ-008 The block SHALL have port i_flush, input, 1: abandon any in-flight operation.
REQ-009 The block SHALL have port o_done, output, 1: one-cycle pulse qualifying o_result.
REQ-010 The block SHALL have port o_result, output, XLEN: operation result, held until the next accept.
REQ-011 The block SHALL have port o_busy, output, 1: operation in flight, used as pipeline stall.

Function
REQ-012 A request SHALL be accepted on a rising edge where i_valid && o_ready && !i_flush; i_op, i_a and i_b SHALL be captured at that edge and ignored afterwards.
REQ-013 The FSM SHALL have states IDLE, MUL, DIV, FIX, DONE; o_ready = 1 in IDLE and DONE only; o_busy = 1 in MUL, DIV and FIX.
REQ-014 Multiply path: accept goes to MUL, and the next edge goes to DONE with the result registered; o_done SHALL be high exactly 2 cycles after the accept edge.
REQ-015 Multiply results SHALL follow the standard: MUL gives the low 32 bits; MULH gives the high 32 bits of signed×signed; MULHSU gives the high 32 bits of signed i_a × unsigned i_b; MULHU gives the high 32 bits of unsigned×unsigned.
REQ-016 Divide path: accept goes to DIV with a 5-bit counter at 31; DIV runs one restoring step per cycle on operand magnitudes (unsigned ops use raw values) and exits to FIX when the counter reaches 0.
REQ-017 FIX SHALL apply signs: quotient negated when signs differ (signed ops); remainder takes the sign of the dividend. FIX goes to DONE, so o_done is high exactly 34 cycles after the accept edge.
REQ-018 Divide by zero SHALL bypass DIV and go directly to DONE (o_done 1 cycle after accept): DIV/DIVU give 0xFFFFFFFF, REM/REMU give i_a.
REQ-019 Signed overflow (DIV/REM with i_a = 0x80000000, i_b = 0xFFFFFFFF) SHALL bypass DIV the same way: DIV gives 0x80000000, REM gives 0.
REQ-020 DONE lasts one cycle; it goes to IDLE, or directly to MUL/DIV/DONE if a new request is accepted in DONE (back-to-back, no bubble).
REQ-021 i_flush SHALL force IDLE at the next edge from any state, suppress o_done for the flushed operation and leave o_result unchanged; flush in the same cycle as i_valid SHALL prevent the accept.
REQ-022 o_result and o_done SHALL be registered outputs, with no combinational path from i_a, i_b or i_op.
REQ-023 The counter SHALL never wrap: DIV exits on the cycle the counter is 0.

Reset
REQ-024 i_rst SHALL asynchronously force: state IDLE, o_done 0, o_result 0, counter 0, all operand/remainder/quotient registers 0.
REQ-025 Reset asserted mid-operation SHALL discard the operation with no o_done, and the first accept after release SHALL behave as from power-up.

Structure
REQ-026 The funct3 op encodings and the FSM state enum SHALL live in the shared package mdu_pkg, alongside the existing ALU control constants.
REQ-027 One sub-module, mdu_div_step, SHALL be used: combinational single restoring step (remainder, quotient, divisor in; next remainder, next quotient out).
REQ-028 The 32×32 multiply SHALL be a single 33×33 signed product that covers all four multiply variants by sign-extending or zero-extending each operand.

Verification
REQ-029 The bench SHALL check: MULHSU, i_a = 0xFFFFFFFF, i_b = 0xFFFFFFFF -> o_done at +2 cycles, o_result 0xFFFFFFFF.
REQ-030 The bench SHALL check: DIV, i_a = -7 (0xFFFFFFF9), i_b = 2 -> o_done at +34, o_result 0xFFFFFFFD; then REM with the same operands -> 0xFFFFFFFF.
REQ-031 The bench SHALL check: DIVU, i_b = 0 -> o_done at +1, 0xFFFFFFFF; DIV, 0x80000000 / 0xFFFFFFFF -> o_done at +1, 0x80000000.
REQ-032 The bench SHALL check: DIV accepted, i_flush at cycle +10 -> IDLE next edge, no o_done, o_result unchanged, o_ready 1.
REQ-033 The bench SHALL check: MUL 3×5 accepted in the DONE cycle of a prior DIVU 100/7 -> results 14 then 15, no idle cycle between.
REQ-034 The bench SHALL check: i_rst pulsed at DIV cycle +20 -> all outputs 0 immediately, no o_done; the next MULHU 0x80000000×4 returns 2.
